// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, FSM states and lane helpers shared by the memory-access stage.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    function automatic logic [3:0] be_of(logic [1:0] lo, logic [1:0] sz);
        return sz == MEM_BYTE ? 4'b0001 << lo :
               sz == MEM_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] lanes_of(logic [31:0] sd, logic [1:0] sz);
        return sz == MEM_BYTE ? {4{sd[7:0]}} : sz == MEM_HALF ? {2{sd[15:0]}} : sd;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: pipeline-side and data-memory-side signals of the memory-access stage.
interface mem_access_stage_if;
    logic        MemValid, MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [31:0] Address, StoreData;
    logic        DReq, DWe, DAck;
    logic [31:0] DAddr, DWData, DRData;
    logic [3:0]  DBe;
    logic [31:0] LoadData;
    logic        LoadValid, Stall, BusErr, AddrErr;

    modport master (
        input  MemValid, MemRead, MemWrite, MemSigned, MemSize, Address, StoreData, DAck, DRData,
        output DReq, DWe, DAddr, DWData, DBe, LoadData, LoadValid, Stall, BusErr, AddrErr
    );

    modport slave (
        output MemValid, MemRead, MemWrite, MemSigned, MemSize, Address, StoreData, DAck, DRData,
        input  DReq, DWe, DAddr, DWData, DBe, LoadData, LoadValid, Stall, BusErr, AddrErr
    );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata_i[8*addr_lo_i +: 8];
    assign h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign data_o = size_i == MEM_BYTE ? {{24{signed_i & b[7]}}, b} :
                    size_i == MEM_HALF ? {{16{signed_i & h[15]}}, h} : rdata_i;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: req/ack data-memory access with pipeline stall, timeout and load alignment.
// MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with AddrErr instead of forcing alignment.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic Clk,
    input  logic Rst,
    mem_access_stage_if.master bus
);
    localparam logic [7:0] max_wait_c = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dreq_q, dreq_d, dwe_q, dwe_d, rd_q, rd_d, sgn_q, sgn_d;
    logic        berr_q, berr_d, aerr_q, aerr_d;
    logic [31:0] daddr_q, daddr_d, dwdata_q, dwdata_d, load_q, load_d, ext;
    logic [3:0]  dbe_q, dbe_d;
    logic [1:0]  lo_q, lo_d, size_q, size_d, size_n, lo_n;
    logic        access, misalign, start;

    assign size_n = (bus.MemSize == MEM_BYTE || bus.MemSize == MEM_HALF) ? bus.MemSize : MEM_WORD;
    // Low bits are forced aligned; with the check enabled misaligned accesses never reach this path
    assign lo_n = size_n == MEM_BYTE ? bus.Address[1:0] :
                  size_n == MEM_HALF ? {bus.Address[1], 1'b0} : 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (size_n == MEM_HALF && bus.Address[0]) || (size_n == MEM_WORD && bus.Address[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign access = bus.MemValid & (bus.MemRead | bus.MemWrite);
    assign start  = state_q == ST_IDLE && access && !misalign;

    load_align u_align (.rdata_i(bus.DRData), .addr_lo_i(lo_q), .size_i(size_q), .signed_i(sgn_q), .data_o(ext));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dreq_d   = dreq_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dbe_d    = dbe_q;
        rd_d     = rd_q;
        lo_d     = lo_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        load_d   = load_q;
        berr_d   = 1'b0;
        aerr_d   = state_q == ST_IDLE && access && misalign;
        if (start) begin
            state_d  = ST_WAIT;
            cnt_d    = 8'd1;
            dreq_d   = 1'b1;
            dwe_d    = bus.MemWrite;
            daddr_d  = {bus.Address[31:2], 2'b00};
            dwdata_d = lanes_of(bus.StoreData, size_n);
            dbe_d    = be_of(lo_n, size_n);
            rd_d     = bus.MemRead;
            lo_d     = lo_n;
            size_d   = size_n;
            sgn_d    = bus.MemSigned;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + 8'd1;
            if (bus.DAck) begin
                state_d = ST_RESP;
                dreq_d  = 1'b0;
                load_d  = rd_q ? ext : load_q;
            end else if (cnt_q == max_wait_c) begin
                state_d = ST_RESP;
                dreq_d  = 1'b0;
                berr_d  = 1'b1;
                load_d  = 32'd0;
            end
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= 32'd0;
            dwdata_q <= 32'd0;
            dbe_q    <= 4'd0;
            rd_q     <= 1'b0;
            lo_q     <= 2'd0;
            size_q   <= MEM_BYTE;
            sgn_q    <= 1'b0;
            load_q   <= 32'd0;
            berr_q   <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dbe_q    <= dbe_d;
            rd_q     <= rd_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            load_q   <= load_d;
            berr_q   <= berr_d;
            aerr_q   <= aerr_d;
        end
    end

    assign bus.DReq      = dreq_q;
    assign bus.DWe       = dwe_q;
    assign bus.DAddr     = daddr_q;
    assign bus.DWData    = dwdata_q;
    assign bus.DBe       = dbe_q;
    assign bus.LoadData  = load_q;
    assign bus.LoadValid = state_q == ST_RESP && rd_q;
    assign bus.Stall     = start || state_q == ST_WAIT;
    assign bus.BusErr    = berr_q;
    assign bus.AddrErr   = aerr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random accesses against a behavioural model of the stage.
module tb_mem_access_stage;
    localparam int MW = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_ld = 32'd0;

    mem_access_stage_if bus ();
    mem_access_stage #(.MAX_WAIT(MW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int eff_lo(bit [1:0] sz, bit [31:0] a);
        int lo = int'(a % 4);
        return sz == 0 ? lo : sz == 1 ? (lo / 2) * 2 : 0;
    endfunction

    function automatic bit [31:0] exp_be(bit [1:0] sz, int lo);
        return sz == 0 ? 32'd1 << lo : sz == 1 ? 32'd3 << lo : 32'd15;
    endfunction

    function automatic bit [31:0] exp_wd(bit [1:0] sz, bit [31:0] sd);
        return sz == 0 ? 32'(sd[7:0]) * 32'h0101_0101 : sz == 1 ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    endfunction

    function automatic bit [31:0] exp_ld(bit [1:0] sz, bit sg, int lo, bit [31:0] rd);
        bit [31:0] v = rd >> (8 * lo);
        if (sz == 0) begin
            v = v % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else v = rd;
        return v;
    endfunction

    function automatic bit misaligned(bit [1:0] sz, bit [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 1 && a % 2 != 0) || (sz >= 2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // d = WAIT cycles that elapse before DAck; d >= MW means DAck never comes in time
    task automatic run_xfer(input bit rd, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                            input bit [31:0] sd, input int d, input bit [31:0] rdat);
        int lo, nw;
        bit acked;
        @(negedge Clk);
        bus.MemValid = 1'b1; bus.MemRead = rd; bus.MemWrite = !rd; bus.MemSize = sz;
        bus.MemSigned = sg; bus.Address = a; bus.StoreData = sd; bus.DAck = 1'b0;
        #1;
        if (misaligned(sz, a)) begin
            chk("stall_mis", bus.Stall, 0);
            @(negedge Clk);
            bus.MemValid = 1'b0;
            chk("addrerr", bus.AddrErr, 1);
            chk("dreq_mis", bus.DReq, 0);
            @(negedge Clk);
            chk("addrerr_clr", bus.AddrErr, 0);
            return;
        end
        chk("stall_start", bus.Stall, 1);
        lo = eff_lo(sz, a);
        acked = d < MW;
        nw = acked ? d + 1 : MW;
        for (int i = 1; i <= nw; i++) begin
            @(negedge Clk);
            bus.DAck = 1'b0;
            chk("dreq_wait", bus.DReq, 1);
            chk("stall_wait", bus.Stall, 1);
            chk("lv_wait", bus.LoadValid, 0);
            if (i == 1) begin
                chk("dwe", bus.DWe, !rd);
                chk("daddr", bus.DAddr, a & 32'hFFFF_FFFC);
                chk("dbe", bus.DBe, exp_be(sz, lo));
                if (!rd) chk("dwdata", bus.DWData, exp_wd(sz, sd));
            end
            if (acked && i == nw) begin
                bus.DAck = 1'b1;
                bus.DRData = rdat;
            end
        end
        @(negedge Clk);
        bus.DAck = 1'b0;
        bus.DRData = $urandom;
        if (!acked) last_ld = 32'd0;
        else if (rd) last_ld = exp_ld(sz, sg, lo, rdat);
        chk("dreq_resp", bus.DReq, 0);
        chk("stall_resp", bus.Stall, 0);
        chk("lv_resp", bus.LoadValid, rd);
        chk("buserr", bus.BusErr, !acked);
        chk("loaddata", bus.LoadData, last_ld);
        @(negedge Clk);
        bus.MemValid = 1'b0;
        #1;
        chk("lv_idle", bus.LoadValid, 0);
        chk("buserr_idle", bus.BusErr, 0);
        chk("stall_idle", bus.Stall, 0);
    endtask

    initial begin
        bus.MemValid = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemSize = 0; bus.MemSigned = 0;
        bus.Address = 0; bus.StoreData = 0; bus.DAck = 0; bus.DRData = 0;
        repeat (2) @(negedge Clk);
        chk("rst_dreq", bus.DReq, 0);
        chk("rst_dbe", bus.DBe, 0);
        chk("rst_daddr", bus.DAddr, 0);
        chk("rst_ld", bus.LoadData, 0);
        chk("rst_lv", bus.LoadValid, 0);
        Rst = 1'b1;
        // live slot with neither read nor write must not start anything
        @(negedge Clk);
        bus.MemValid = 1'b1;
        #1 chk("nop_stall", bus.Stall, 0);
        @(negedge Clk);
        bus.MemValid = 1'b0;
        chk("nop_dreq", bus.DReq, 0);

        run_xfer(1, 2'b00, 1, 32'h103, 32'h0, 2, 32'h80AA_BBCC);
        run_xfer(0, 2'b01, 0, 32'h202, 32'h1234_ABCD, 0, 32'h0);
        run_xfer(1, 2'b10, 0, 32'h500, 32'h0, 10, 32'hDEAD_BEEF);
        run_xfer(1, 2'b01, 0, 32'h301, 32'h0, 1, 32'h1122_8344);
        run_xfer(1, 2'b10, 0, 32'h604, 32'h0, MW - 1, 32'h5A5A_1234);
        run_xfer(1, 2'b11, 1, 32'h70A, 32'h0, 0, 32'h8765_4321);

        // asynchronous reset in the middle of WAIT
        @(negedge Clk);
        bus.MemValid = 1; bus.MemRead = 1; bus.MemWrite = 0; bus.MemSize = 2'b10; bus.Address = 32'h800;
        @(negedge Clk);
        chk("pre_rst_dreq", bus.DReq, 1);
        #2 Rst = 1'b0;
        #1 chk("async_dreq", bus.DReq, 0);
        bus.MemValid = 1'b0;
        last_ld = 32'd0;
        @(negedge Clk);
        Rst = 1'b1;
        chk("post_rst_dbe", bus.DBe, 0);
        chk("post_rst_ld", bus.LoadData, 0);
        run_xfer(1, 2'b10, 0, 32'h400, 32'h0, 1, 32'hCAFE_F00D);

        for (int k = 0; k < 80; k++)
            run_xfer(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, MW + 1)), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
